// File: rtl/button_step_controller.sv
// Push-button step sequencer: synchronises and debounces a raw button pin, turns each
// qualified press (plus auto-repeat while held) into a step pulse driving a wrap-around count.
module button_step_controller #(
  parameter int WIDTH           = 4,
  parameter int MAX_COUNT       = 15,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_in,
  input  logic             enable,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap,
  output logic             btn_stable
);

  localparam int DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DELAY_LAST  = (REPEAT_DELAY > 0) ? TIMER_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH-1:0]   MAX_VAL     = WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HELD
  } state_t;

  state_t             state;
  logic               btn_meta;
  logic               btn_sync;
  logic [DB_W-1:0]    db_cnt;
  logic [TIMER_W-1:0] timer;
  logic               issue_step;
  logic [WIDTH-1:0]   next_count;
  logic               next_wrap;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= button_in;
      btn_sync <= btn_meta;
    end
  end

  // A new level is accepted only after it has disagreed with btn_stable for
  // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt     <= '0;
      btn_stable <= 1'b0;
    end else if (btn_sync != btn_stable) begin
      if (db_cnt == DB_LAST) begin
        btn_stable <= btn_sync;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Step decision; a release always wins over a repeat step due in the same cycle
  always_comb begin
    issue_step = 1'b0;
    case (state)
      IDLE:    issue_step = btn_stable;
      DELAY:   issue_step = btn_stable && (timer == DELAY_LAST);
      REPEAT:  issue_step = btn_stable && (timer == PERIOD_LAST);
      default: issue_step = 1'b0;
    endcase
  end

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (clear) begin
      next_count = '0;
    end else if (issue_step && enable) begin
      if (!dir) begin
        if (count == MAX_VAL) begin
          next_count = '0;
          next_wrap  = 1'b1;
        end else begin
          next_count = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          next_count = MAX_VAL;
          next_wrap  = 1'b1;
        end else begin
          next_count = count - 1'b1;
        end
      end
    end
  end

  // Press sequencer with registered step/wrap/count so they appear together
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
      count <= '0;
    end else begin
      step  <= issue_step;
      wrap  <= next_wrap;
      count <= next_count;
      case (state)
        IDLE: begin
          timer <= '0;
          if (btn_stable) begin
            state <= (REPEAT_DELAY == 0) ? HELD : DELAY;
          end
        end
        DELAY: begin
          if (!btn_stable) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == DELAY_LAST) begin
            state <= REPEAT;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!btn_stable) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == PERIOD_LAST) begin
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HELD: begin
          timer <= '0;
          if (!btn_stable) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_step_controller.sv
// Randomised scoreboard bench for button_step_controller: a press-timing reference model
// pushes expected outputs per clock edge and a monitor pops and compares them.
module tb_button_step_controller;

  localparam int WIDTH     = 4;
  localparam int MAX_COUNT = 15;
  localparam int DB        = 4;
  localparam int RD        = 8;
  localparam int RP        = 4;
  localparam int MODULUS   = MAX_COUNT + 1;
  localparam int NCYC      = 6000;

  typedef struct {
    int count;
    int step;
    int wrap;
    int stable;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             button_in;
  logic             enable;
  logic             dir;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             wrap;
  logic             btn_stable;

  exp_t expq[$];
  bit   pinh[$];
  bit   m_stable;
  int   m_held;
  int   m_count;
  int   m_n;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  int   seg_left = 0;
  bit   seg_lvl = 1'b0;

  button_step_controller #(
    .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .button_in(button_in), .enable(enable), .dir(dir),
    .clear(clear), .count(count), .step(step), .wrap(wrap), .btn_stable(btn_stable)
  );

  always #5 clk = ~clk;

  // Synchronised pin level seen in cycle i after the last reset (pin sampled two edges earlier)
  function automatic bit syncAt(int i);
    if (i < 2) return 1'b0;
    return pinh[i-2];
  endfunction

  task automatic modelEdge(input bit rst, input bit pin, input bit en, input bit dr, input bit clr);
    exp_t e;
    bit   mstep;
    bit   mwrap;
    bit   flip;
    int   k;
    if (rst) begin
      pinh.delete();
      m_stable = 1'b0;
      m_held   = 0;
      m_count  = 0;
      m_n      = 0;
      e = '{0, 0, 0, 0};
    end else begin
      m_n++;
      k = m_held - 1;
      mstep = m_stable && (k == 0 || (RD > 0 && k >= RD && ((k - RD) % RP) == 0));
      flip = 1'b1;
      for (int i = m_n - 1; i >= m_n - DB; i--) begin
        if (syncAt(i) == m_stable) flip = 1'b0;
      end
      pinh.push_back(pin);
      if (flip) m_stable = !m_stable;
      m_held = m_stable ? m_held + 1 : 0;
      mwrap = 1'b0;
      if (clr) begin
        m_count = 0;
      end else if (mstep && en) begin
        if (!dr) begin
          mwrap   = (m_count == MAX_COUNT);
          m_count = (m_count + 1) % MODULUS;
        end else begin
          mwrap   = (m_count == 0);
          m_count = (m_count + MODULUS - 1) % MODULUS;
        end
      end
      e = '{m_count, int'(mstep), int'(mwrap), int'(m_stable)};
    end
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input int cyc);
    reset  = 1'b0;
    enable = 1'b1;
    dir    = 1'b0;
    clear  = 1'b0;
    if (cyc < 2) begin
      reset     = 1'b1;
      button_in = 1'b0;
    end else if (cyc < 32) begin
      button_in = 1'b1;
    end else if (cyc < 60) begin
      button_in = 1'b0;
    end else if (cyc < 110) begin
      button_in = ((cyc - 60) % 5) < 3;
    end else if (cyc < 190) begin
      button_in = (cyc < 170);
      reset     = (cyc == 145);
    end else begin
      if (seg_left == 0) begin
        seg_lvl  = !seg_lvl;
        seg_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DB - 1) : $urandom_range(DB, 50);
      end
      seg_left--;
      button_in = seg_lvl;
      reset     = ($urandom_range(0, 499) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      dir       = (cyc / 200) % 2 == 1;
      clear     = ($urandom_range(0, 63) == 0);
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    button_in = 1'b0;
    enable    = 1'b1;
    dir       = 1'b0;
    clear     = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      modelEdge(reset, button_in, enable, dir, clear);
      #1;
      applyStimulus(cyc);
    end
    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      checkOutput("queue_drain", expq.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: one expected record per clock edge, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        if (!done) checkOutput("queue_empty", 0, 1);
      end else begin
        e = expq.pop_front();
        checkOutput("count", int'(count), e.count);
        checkOutput("step", int'(step), e.step);
        checkOutput("wrap", int'(wrap), e.wrap);
        checkOutput("btn_stable", int'(btn_stable), e.stable);
      end
    end
  end

endmodule
